// File: rtl/hazard_stall_unit.sv
// Load-use / memory-busy stall and flush control for a 5-stage pipeline.
// Shadows EX/MEM/WB destination state and counts stall cycles.
module hazard_stall_unit #(
  parameter int unsigned REG_BITS = 4,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_decode,
  input  logic [REG_BITS-1:0]      rs1_decode,
  input  logic [REG_BITS-1:0]      rs2_decode,
  input  logic                     use_rs1_decode,
  input  logic                     use_rs2_decode,
  input  logic [REG_BITS-1:0]      rd_decode,
  input  logic                     wre_decode,
  input  logic                     load_decode,
  input  logic                     mem_busy,
  input  logic                     flush,
  output logic                     stall_fetch,
  output logic                     stall_decode,
  output logic                     stall_execute,
  output logic                     stall_memory,
  output logic                     bubble_execute,
  output logic                     kill_decode,
  output logic [2**REG_BITS-1:0]   pending_mask,
  output logic [CNT_BITS-1:0]      stall_count
);

  localparam int unsigned NumRegs = 2 ** REG_BITS;

  typedef struct packed {
    logic                valid;
    logic [REG_BITS-1:0] rd;
    logic                wre;
    logic                load;
  } shadow_t;

  shadow_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic rs1_hit, rs2_hit, load_use;

  always_comb begin
    rs1_hit  = use_rs1_decode && (ex_q.rd == rs1_decode);
    rs2_hit  = use_rs2_decode && (ex_q.rd == rs2_decode);
    load_use = valid_decode && ex_q.valid && ex_q.wre && ex_q.load && (rs1_hit || rs2_hit);
  end

  always_comb begin
    stall_fetch    = 1'b0;
    stall_decode   = 1'b0;
    stall_execute  = 1'b0;
    stall_memory   = 1'b0;
    bubble_execute = 1'b0;
    kill_decode    = 1'b0;
    ex_d           = ex_q;
    mem_d          = mem_q;
    wb_d           = wb_q;
    if (mem_busy) begin
      stall_fetch   = 1'b1;
      stall_decode  = 1'b1;
      stall_execute = 1'b1;
      stall_memory  = 1'b1;
      // WB retires while MEM holds, so its slot empties.
      wb_d.valid    = 1'b0;
    end else begin
      mem_d = ex_q;
      wb_d  = mem_q;
      if (flush) begin
        kill_decode    = 1'b1;
        bubble_execute = 1'b1;
        ex_d           = '0;
      end else if (load_use) begin
        stall_fetch    = 1'b1;
        stall_decode   = 1'b1;
        bubble_execute = 1'b1;
        ex_d           = '0;
      end else begin
        ex_d = '{valid: valid_decode, rd: rd_decode, wre: wre_decode, load: load_decode};
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_fetch && (cnt_q != {CNT_BITS{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_BITS-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < NumRegs; i++) begin
      pending_mask[i] = (ex_q.valid  && ex_q.wre  && (ex_q.rd  == REG_BITS'(i))) ||
                        (mem_q.valid && mem_q.wre && (mem_q.rd == REG_BITS'(i))) ||
                        (wb_q.valid  && wb_q.wre  && (wb_q.rd  == REG_BITS'(i)));
    end
  end

  assign stall_count = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: vector table, hand-written corner
// sequences and a randomized run against a pipeline reference model.
module tb_hazard_stall_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, valid_decode, use_rs1_decode, use_rs2_decode, wre_decode, load_decode;
  logic mem_busy, flush;
  logic [3:0] rs1_decode, rs2_decode, rd_decode;
  logic stall_fetch, stall_decode, stall_execute, stall_memory, bubble_execute, kill_decode;
  logic [15:0] pending_mask, stall_count;
  logic sf4, sd4, se4, sm4, bx4, kd4;
  logic [15:0] pm4;
  logic [3:0] cnt4;

  hazard_stall_unit #(.REG_BITS(4), .CNT_BITS(16)) dut (
    .clk(clk), .rst(rst), .valid_decode(valid_decode), .rs1_decode(rs1_decode),
    .rs2_decode(rs2_decode), .use_rs1_decode(use_rs1_decode), .use_rs2_decode(use_rs2_decode),
    .rd_decode(rd_decode), .wre_decode(wre_decode), .load_decode(load_decode),
    .mem_busy(mem_busy), .flush(flush), .stall_fetch(stall_fetch), .stall_decode(stall_decode),
    .stall_execute(stall_execute), .stall_memory(stall_memory),
    .bubble_execute(bubble_execute), .kill_decode(kill_decode),
    .pending_mask(pending_mask), .stall_count(stall_count)
  );

  hazard_stall_unit #(.REG_BITS(4), .CNT_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .valid_decode(valid_decode), .rs1_decode(rs1_decode),
    .rs2_decode(rs2_decode), .use_rs1_decode(use_rs1_decode), .use_rs2_decode(use_rs2_decode),
    .rd_decode(rd_decode), .wre_decode(wre_decode), .load_decode(load_decode),
    .mem_busy(mem_busy), .flush(flush), .stall_fetch(sf4), .stall_decode(sd4),
    .stall_execute(se4), .stall_memory(sm4), .bubble_execute(bx4), .kill_decode(kd4),
    .pending_mask(pm4), .stall_count(cnt4)
  );

  typedef struct packed {
    logic       rst;
    logic       v;
    logic [3:0] r1;
    logic [3:0] r2;
    logic       u1;
    logic       u2;
    logic [3:0] rd;
    logic       w;
    logic       l;
    logic       busy;
    logic       fl;
  } in_t;

  typedef struct {
    in_t         in;
    logic [5:0]  ctl;
    logic [15:0] pm;
    int unsigned cnt;
    string       name;
  } vec_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] rd;
    logic       wre;
    logic       load;
  } stage_t;

  // Reference pipeline: index 0 = EX, 1 = MEM, 2 = WB.
  stage_t      pipe [3];
  int unsigned cnt_m;
  in_t         cur;
  vec_t        tbl[$];
  int          checks = 0;
  int          errors = 0;

  // Control vector order: {fetch, decode, execute, memory, bubble, kill}.
  localparam logic [5:0] CtlIdle   = 6'b000000;
  localparam logic [5:0] CtlFreeze = 6'b111100;
  localparam logic [5:0] CtlHazard = 6'b110010;
  localparam logic [5:0] CtlFlush  = 6'b000011;

  function automatic in_t mk(input logic v, input logic [3:0] r1, input logic [3:0] r2,
                             input logic u1, input logic u2, input logic [3:0] rd,
                             input logic w, input logic l, input logic busy, input logic fl);
    in_t i;
    i = '{rst: 1'b0, v: v, r1: r1, r2: r2, u1: u1, u2: u2, rd: rd, w: w, l: l,
          busy: busy, fl: fl};
    return i;
  endfunction

  function automatic logic model_hazard();
    return cur.v && pipe[0].valid && pipe[0].wre && pipe[0].load &&
           ((cur.u1 && cur.r1 == pipe[0].rd) || (cur.u2 && cur.r2 == pipe[0].rd));
  endfunction

  function automatic logic [5:0] model_ctl();
    if (cur.busy) return CtlFreeze;
    if (cur.fl) return CtlFlush;
    if (model_hazard()) return CtlHazard;
    return CtlIdle;
  endfunction

  function automatic logic [15:0] model_pm();
    logic [15:0] m;
    m = '0;
    for (int s = 0; s < 3; s++) if (pipe[s].valid && pipe[s].wre) m[pipe[s].rd] = 1'b1;
    return m;
  endfunction

  task automatic model_step();
    logic stalled;
    stalled = model_ctl() == CtlFreeze || model_ctl() == CtlHazard;
    if (cur.rst) begin
      for (int s = 0; s < 3; s++) pipe[s] = '0;
      cnt_m = 0;
    end else begin
      if (stalled && cnt_m < 65535) cnt_m++;
      if (cur.busy) begin
        pipe[2].valid = 1'b0;
      end else begin
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = (cur.fl || model_hazard()) ? stage_t'(0) :
                  '{valid: cur.v, rd: cur.rd, wre: cur.w, load: cur.l};
      end
    end
  endtask

  task automatic apply(input in_t i);
    @(negedge clk);
    rst = i.rst; valid_decode = i.v; rs1_decode = i.r1; rs2_decode = i.r2;
    use_rs1_decode = i.u1; use_rs2_decode = i.u2; rd_decode = i.rd;
    wre_decode = i.w; load_decode = i.l; mem_busy = i.busy; flush = i.fl;
    cur = i;
    #1;
  endtask

  task automatic check(input string nm, input logic [5:0] ectl, input logic [15:0] epm,
                       input int unsigned ecnt);
    logic [5:0] act, act4;
    logic [3:0] ecnt4;
    act   = {stall_fetch, stall_decode, stall_execute, stall_memory, bubble_execute, kill_decode};
    act4  = {sf4, sd4, se4, sm4, bx4, kd4};
    ecnt4 = (ecnt > 15) ? 4'hf : ecnt[3:0];
    checks += 5;
    if (act !== ectl) begin
      errors++; $display("FAIL %s ctl: got %b want %b", nm, act, ectl);
    end
    if (act4 !== ectl) begin
      errors++; $display("FAIL %s ctl4: got %b want %b", nm, act4, ectl);
    end
    if (pending_mask !== epm || pm4 !== epm) begin
      errors++; $display("FAIL %s pending_mask: got %h/%h want %h", nm, pending_mask, pm4, epm);
    end
    if (stall_count !== ecnt[15:0]) begin
      errors++; $display("FAIL %s stall_count: got %0d want %0d", nm, stall_count, ecnt);
    end
    if (cnt4 !== ecnt4) begin
      errors++; $display("FAIL %s stall_count4: got %0d want %0d", nm, cnt4, ecnt4);
    end
  endtask

  task automatic cyc(input in_t i, input string nm, input logic [5:0] ectl,
                     input logic [15:0] epm, input int unsigned ecnt);
    apply(i);
    check(nm, ectl, epm, ecnt);
    model_step();
  endtask

  task automatic do_reset();
    in_t i;
    i = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    i.rst = 1'b1;
    apply(i);
    model_step();
  endtask

  task automatic add(input in_t i, input logic [5:0] c, input logic [15:0] p,
                     input int unsigned n, input string nm);
    vec_t e;
    e.in = i; e.ctl = c; e.pm = p; e.cnt = n; e.name = nm;
    tbl.push_back(e);
  endtask

  in_t idle, use_r3, ld_r3;

  initial begin
    idle   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ld_r3  = mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    use_r3 = mk(1, 3, 0, 1, 0, 4, 1, 0, 0, 0);

    add(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0), CtlIdle,   16'h0000, 0, "reset_ld_r5");
    add(mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 0), CtlHazard, 16'h0020, 0, "load_use_rs1");
    add(mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 0), CtlIdle,   16'h0020, 1, "after_stall");
    add(mk(1, 6, 0, 1, 0, 5, 1, 0, 0, 0), CtlIdle,   16'h0060, 1, "alu_in_ex");
    add(mk(1, 5, 0, 1, 0, 7, 1, 1, 0, 0), CtlIdle,   16'h0060, 1, "alu_r5_no_stall");
    add(mk(1, 0, 7, 0, 0, 0, 0, 0, 0, 0), CtlIdle,   16'h00e0, 1, "rs2_unused");
    add(idle,                             CtlIdle,   16'h00a0, 1, "drain1");
    add(idle,                             CtlIdle,   16'h0080, 1, "drain2");
    add(mk(1, 0, 0, 0, 0, 9, 1, 1, 0, 0), CtlIdle,   16'h0000, 1, "drain3_ld_r9");
    add(mk(1, 0, 9, 0, 1, 1, 1, 0, 0, 0), CtlHazard, 16'h0200, 1, "load_use_rs2");
    add(idle,                             CtlIdle,   16'h0200, 2, "after_rs2");

    do_reset();
    foreach (tbl[k]) cyc(tbl[k].in, tbl[k].name, tbl[k].ctl, tbl[k].pm, tbl[k].cnt);

    // Freeze for three cycles, then the pending hazard stalls once.
    do_reset();
    cyc(ld_r3, "fz_ld", CtlIdle, 16'h0000, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(mk(1, 3, 0, 1, 0, 4, 1, 0, 1, 0), "fz_busy", CtlFreeze, 16'h0008, i);
    end
    cyc(use_r3, "fz_hazard", CtlHazard, 16'h0008, 3);
    cyc(idle, "fz_end", CtlIdle, 16'h0008, 4);

    // Flush beats hazard; busy beats flush.
    do_reset();
    cyc(ld_r3, "fl_ld", CtlIdle, 16'h0000, 0);
    cyc(mk(1, 3, 0, 1, 0, 4, 1, 0, 0, 1), "fl_vs_hazard", CtlFlush, 16'h0008, 0);
    cyc(ld_r3, "fl_after", CtlIdle, 16'h0008, 0);
    cyc(mk(1, 3, 0, 1, 0, 4, 1, 0, 1, 1), "fl_vs_busy", CtlFreeze, 16'h0008, 0);
    cyc(mk(1, 3, 0, 1, 0, 4, 1, 0, 0, 1), "fl_accepted", CtlFlush, 16'h0008, 1);

    // Saturation: the 4-bit instance stops at 15.
    do_reset();
    cyc(ld_r3, "sat_ld", CtlIdle, 16'h0000, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(mk(1, 3, 0, 1, 0, 4, 1, 0, 1, 0), "sat_busy", CtlFreeze, 16'h0008, i);
    end
    cyc(use_r3, "sat_hazard", CtlHazard, 16'h0008, 20);
    cyc(idle, "sat_hold", CtlIdle, 16'h0008, 21);

    // Reset in the middle of a freeze with r3 and r5 pending.
    do_reset();
    cyc(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0), "rm_r5", CtlIdle, 16'h0000, 0);
    cyc(ld_r3, "rm_ld_r3", CtlIdle, 16'h0020, 0);
    begin
      in_t i;
      i = mk(1, 3, 0, 1, 0, 4, 1, 0, 1, 0);
      i.rst = 1'b1;
      cyc(i, "rm_freeze_rst", CtlFreeze, 16'h0028, 0);
    end
    cyc(use_r3, "rm_after", CtlIdle, 16'h0000, 0);

    // Randomized run against the reference model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      in_t i;
      i = mk($urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)), 1'($urandom),
             1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0);
      i.rst = $urandom_range(0, 39) == 0;
      apply(i);
      check("random", model_ctl(), model_pm(), cnt_m);
      model_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
